rpn_evaluator: RTL

RPN_EVALUATOR -- requirements
Module: rpn_evaluator

---
 rtl/rpn_evaluator.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/rpn_evaluator.sv
// Fixed-point RPN expression evaluator: fetches tokens from an external queue and runs them on a value stack.
// Optional POW operator is compiled in when RPN_EVALUATOR_POW_EN is defined.
module rpn_evaluator #(
  parameter int INTEGER_PART_WIDTH    = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8,
  parameter int OUTPUT_QUEUE_SIZE     = 64,
  parameter int STACK_SIZE            = 16,
  localparam int NUMBER_WIDTH = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
  localparam int QI           = $clog2(OUTPUT_QUEUE_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUMBER_WIDTH-1:0] x,
  input  logic [QI:0]             length,
  output logic                    queue_read,
  output logic [QI-1:0]           queue_index,
  input  logic [NUMBER_WIDTH:0]   queue_data,
  input  logic                    queue_valid,
  output logic                    busy,
  output logic                    done,
  output logic [NUMBER_WIDTH-1:0] result,
  output logic                    error,
  output logic [2:0]              error_code
);
  localparam int NW  = NUMBER_WIDTH;
  localparam int FW  = FRACTIONAL_PART_WIDTH;
  localparam int DW  = NW + FW;
  localparam int SPW = $clog2(STACK_SIZE);
  localparam int CW  = INTEGER_PART_WIDTH + $clog2(DW);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_EXEC   = 3'd3,
    S_MULT   = 3'd4,
    S_DIVIDE = 3'd5,
`ifdef RPN_EVALUATOR_POW_EN
    S_POWER  = 3'd6,
`endif
    S_FINISH = 3'd7
  } state_t;

  function automatic logic [NW-1:0] fx_mul(input logic [NW-1:0] a, input logic [NW-1:0] b);
    logic signed [2*NW-1:0] p;
    p = $signed({{NW{a[NW-1]}}, a}) * $signed({{NW{b[NW-1]}}, b});
    fx_mul = p[FW +: NW];
  endfunction

  function automatic logic [NW-1:0] fx_abs(input logic [NW-1:0] v);
    fx_abs = v[NW-1] ? (~v + NW'(1)) : v;
  endfunction

  state_t            state_q, state_d;
  logic [SPW:0]      sp_q, sp_d;
  logic [QI-1:0]     idx_q, idx_d;
  logic [QI:0]       len_q, len_d;
  logic [NW-1:0]     x_q, x_d;
  logic [NW:0]       tok_q, tok_d;
  logic [2:0]        err_q, err_d;
  logic [NW-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic [NW-1:0]     rem_q, rem_d;
  logic [DW-1:0]     quo_q, quo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
`ifdef RPN_EVALUATOR_POW_EN
  logic [NW-1:0]     acc_q, acc_d;
`endif
  logic              queue_read_q, queue_read_d, busy_q, busy_d, done_q, done_d;
  logic              error_q, error_d;
  logic [2:0]        error_code_q, error_code_d;
  logic [NW-1:0]     result_q, result_d;

  logic [NW-1:0]     stack_q [STACK_SIZE];
  logic              stk_we_s;
  logic [SPW-1:0]    stk_wa_s;
  logic [NW-1:0]     stk_wd_s;
  logic [NW-1:0]     a_s, b_s;
  logic              is_bin_s, advance_s, ge_s;
  logic [NW:0]       rem_sh_s;
  logic [NW-1:0]     rem_nx_s, quo_lo_s;
  logic [DW-1:0]     quo_nx_s;
  logic [QI:0]       idx_nx_s;

  assign a_s = stack_q[sp_q[SPW-1:0] - SPW'(2)];
  assign b_s = stack_q[sp_q[SPW-1:0] - SPW'(1)];

  // Next-state, datapath and output computation.
  always_comb begin
    state_d = state_q;  sp_d = sp_q;  idx_d = idx_q;  len_d = len_q;  x_d = x_q;
    tok_d = tok_q;  err_d = err_q;  op_a_d = op_a_q;  op_b_d = op_b_q;
    rem_d = rem_q;  quo_d = quo_q;  cnt_d = cnt_q;  neg_d = neg_q;
`ifdef RPN_EVALUATOR_POW_EN
    acc_d = acc_q;
`endif
    done_d = 1'b0;  result_d = result_q;  error_d = error_q;  error_code_d = error_code_q;
    stk_we_s = 1'b0;  stk_wa_s = sp_q[SPW-1:0];  stk_wd_s = '0;  advance_s = 1'b0;
    case (tok_q[2:0])
      3'd0, 3'd1, 3'd2, 3'd3: is_bin_s = 1'b1;
`ifdef RPN_EVALUATOR_POW_EN
      3'd4:                   is_bin_s = 1'b1;
`endif
      default:                is_bin_s = 1'b0;
    endcase
    // Restoring divider step: one quotient bit per cycle from the dividend MSB.
    rem_sh_s = {rem_q, quo_q[DW-1]};
    ge_s     = rem_sh_s >= {1'b0, op_b_q};
    rem_nx_s = ge_s ? (rem_sh_s[NW-1:0] - op_b_q) : rem_sh_s[NW-1:0];
    quo_nx_s = {quo_q[DW-2:0], ge_s};
    quo_lo_s = neg_q ? (~quo_nx_s[NW-1:0] + NW'(1)) : quo_nx_s[NW-1:0];
    idx_nx_s = {1'b0, idx_q} + (QI+1)'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sp_d = '0;  idx_d = '0;  x_d = x;  len_d = length;  err_d = 3'd0;
          result_d = '0;  error_d = 1'b0;  error_code_d = 3'd0;
          state_d = (length == '0) ? S_FINISH : S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (queue_valid) begin
          tok_d   = queue_data;
          state_d = S_EXEC;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_EXEC: begin
        if (!tok_q[NW] || tok_q[2:0] == 3'd6) begin
          if (sp_q == (SPW+1)'(STACK_SIZE)) begin
            err_d = 3'd2;  state_d = S_FINISH;
          end else begin
            stk_we_s = 1'b1;
            stk_wd_s = tok_q[NW] ? x_q : tok_q[NW-1:0];
            sp_d = sp_q + (SPW+1)'(1);
            advance_s = 1'b1;
          end
        end else if (!is_bin_s) begin
          err_d = 3'd4;  state_d = S_FINISH;
        end else if (sp_q < (SPW+1)'(2)) begin
          err_d = 3'd1;  state_d = S_FINISH;
        end else begin
          op_a_d = a_s;  op_b_d = b_s;
          case (tok_q[2:0])
            3'd0, 3'd1: begin
              stk_we_s = 1'b1;
              stk_wa_s = sp_q[SPW-1:0] - SPW'(2);
              stk_wd_s = (tok_q[2:0] == 3'd0) ? (a_s + b_s) : (a_s - b_s);
              sp_d = sp_q - (SPW+1)'(1);
              advance_s = 1'b1;
            end
            3'd2: begin
              sp_d = sp_q - (SPW+1)'(2);  state_d = S_MULT;
            end
            3'd3: begin
              if (b_s == '0) begin
                err_d = 3'd3;  state_d = S_FINISH;
              end else begin
                op_b_d = fx_abs(b_s);
                quo_d  = {fx_abs(a_s), {FW{1'b0}}};
                rem_d  = '0;  cnt_d = '0;  neg_d = a_s[NW-1] ^ b_s[NW-1];
                sp_d = sp_q - (SPW+1)'(2);  state_d = S_DIVIDE;
              end
            end
`ifdef RPN_EVALUATOR_POW_EN
            3'd4: begin
              if (b_s[NW-1]) begin
                err_d = 3'd4;  state_d = S_FINISH;
              end else begin
                acc_d = NW'(1) << FW;
                cnt_d = CW'(b_s[NW-2:FW]);
                sp_d = sp_q - (SPW+1)'(2);  state_d = S_POWER;
              end
            end
`endif
            default: begin
              err_d = 3'd4;  state_d = S_FINISH;
            end
          endcase
        end
      end
      S_MULT: begin
        stk_we_s = 1'b1;  stk_wd_s = fx_mul(op_a_q, op_b_q);
        sp_d = sp_q + (SPW+1)'(1);  advance_s = 1'b1;
      end
      S_DIVIDE: begin
        rem_d = rem_nx_s;  quo_d = quo_nx_s;
        if (cnt_q == CW'(DW-1)) begin
          stk_we_s = 1'b1;  stk_wd_s = quo_lo_s;
          sp_d = sp_q + (SPW+1)'(1);  advance_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef RPN_EVALUATOR_POW_EN
      S_POWER: begin
        if (cnt_q == '0) begin
          stk_we_s = 1'b1;  stk_wd_s = acc_q;
          sp_d = sp_q + (SPW+1)'(1);  advance_s = 1'b1;
        end else begin
          acc_d = fx_mul(acc_q, op_a_q);
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (err_q != 3'd0) begin
          error_d = 1'b1;  error_code_d = err_q;  result_d = '0;
        end else if (sp_q != (SPW+1)'(1)) begin
          error_d = 1'b1;  error_code_d = 3'd5;  result_d = '0;
        end else begin
          error_d = 1'b0;  error_code_d = 3'd0;  result_d = b_s;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance_s) begin
      if (idx_nx_s == len_q) begin
        state_d = S_FINISH;
      end else begin
        idx_d   = idx_nx_s[QI-1:0];
        state_d = S_FETCH;
      end
    end else begin
      idx_d = idx_d;
    end
    queue_read_d = (state_d == S_FETCH);
    busy_d       = (state_d != S_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;  sp_q <= '0;  idx_q <= '0;  len_q <= '0;  x_q <= '0;
      tok_q <= '0;  err_q <= 3'd0;  op_a_q <= '0;  op_b_q <= '0;
      rem_q <= '0;  quo_q <= '0;  cnt_q <= '0;  neg_q <= 1'b0;
`ifdef RPN_EVALUATOR_POW_EN
      acc_q <= '0;
`endif
      queue_read_q <= 1'b0;  busy_q <= 1'b0;  done_q <= 1'b0;
      result_q <= '0;  error_q <= 1'b0;  error_code_q <= 3'd0;
    end else begin
      state_q <= state_d;  sp_q <= sp_d;  idx_q <= idx_d;  len_q <= len_d;  x_q <= x_d;
      tok_q <= tok_d;  err_q <= err_d;  op_a_q <= op_a_d;  op_b_q <= op_b_d;
      rem_q <= rem_d;  quo_q <= quo_d;  cnt_q <= cnt_d;  neg_q <= neg_d;
`ifdef RPN_EVALUATOR_POW_EN
      acc_q <= acc_d;
`endif
      queue_read_q <= queue_read_d;  busy_q <= busy_d;  done_q <= done_d;
      result_q <= result_d;  error_q <= error_d;  error_code_q <= error_code_d;
    end
  end

  // Value stack storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (stk_we_s) begin
      stack_q[stk_wa_s] <= stk_wd_s;
    end
  end

  assign queue_read  = queue_read_q;
  assign queue_index = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign error       = error_q;
  assign error_code  = error_code_q;
endmodule
